// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration state and the
// bundled memory request that mem_stage hands to the arbiter.
package dmem_arb_pkg;

  localparam int DMEM_DW = 32;
  localparam int DMEM_MW = DMEM_DW / 8;

  typedef enum logic [0:0] {
    S_CORE  = 1'b0,
    S_XLOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [DMEM_MW-1:0] mask;
    logic [DMEM_DW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the core MEM stage (C, fixed priority)
// and an external requester (X) with starvation relief and burst lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DMEM_DW,
  parameter int STARVE_LIMIT = 8,
  localparam int MASK_SIZE   = DATA_WIDTH / 8,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  // core port
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [MASK_SIZE-1:0]  c_mask,
  input  logic [DATA_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  core_stall,
  // external port
  input  logic                  x_valid,
  input  logic                  x_we,
  input  logic [MASK_SIZE-1:0]  x_mask,
  input  logic [DATA_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] x_wdata,
  input  logic                  x_lock,
  output logic                  x_ready,
  output logic                  x_rvalid,
  output logic [DATA_WIDTH-1:0] x_rdata,
  // dmem port
  output logic                  mem_we,
  output logic [MASK_SIZE-1:0]  mem_mask,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // debug visibility
  output arb_state_e            dbg_state,
  output logic [CNT_W-1:0]      dbg_starve
);

  // Handshake: an X beat transfers on a cycle where x_valid && x_ready; X holds
  // its fields stable while x_valid && !x_ready. C has no ready: it is told to
  // hold through core_stall, and its beat transfers whenever c_req && !core_stall.

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic                  we;
    logic [MASK_SIZE-1:0]  mask;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  arb_state_e       state_q;
  logic [CNT_W-1:0] starve_q;
  logic             x_gnt;
  logic             c_gnt;
  req_t             req;

  always_comb begin
    x_gnt = 1'b0;
    c_gnt = 1'b0;
    req   = '0;
    if (!rst) begin
      x_gnt = x_valid && (state_q == S_XLOCK || !c_req || starve_q == LIMIT);
      c_gnt = c_req && state_q == S_CORE && !x_gnt;
    end
    if (x_gnt) begin
      req = '{we: x_we, mask: x_mask, addr: x_addr, wdata: x_wdata};
    end else if (c_gnt) begin
      req = '{we: c_we, mask: c_mask, addr: c_addr, wdata: c_wdata};
    end
  end

  assign mem_we     = req.we;
  assign mem_mask   = req.mask;
  assign mem_addr   = req.addr;
  assign mem_wdata  = req.wdata;
  assign c_rdata    = mem_rdata;
  assign core_stall = c_req && !c_gnt;
  assign x_ready    = x_gnt;
  assign dbg_state  = state_q;
  assign dbg_starve = starve_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CORE;
      starve_q <= '0;
      x_rvalid <= 1'b0;
      x_rdata  <= '0;
    end else begin
      case (state_q)
        S_CORE:  if (x_gnt && x_lock) state_q <= S_XLOCK;
        S_XLOCK: if (!x_valid || !x_lock) state_q <= S_CORE;
        default: state_q <= S_CORE;
      endcase

      // Only consecutive denied cycles of one pending beat count toward relief.
      if (!x_valid || x_gnt) begin
        starve_q <= '0;
      end else if (starve_q != LIMIT) begin
        starve_q <= starve_q + 1'b1;
      end

      x_rvalid <= x_gnt && !x_we;
      if (x_gnt && !x_we) x_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed then randomized checks of dmem_arbiter against a transaction-level
// model of the sharing rules and a reference copy of memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        c_req, c_we, x_valid, x_we, x_lock;
  logic [3:0]  c_mask, x_mask;
  logic [31:0] c_addr, c_wdata, x_addr, x_wdata;
  logic [31:0] c_rdata, x_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_stall, x_ready, x_rvalid, mem_we;
  logic [3:0]  mem_mask;
  arb_state_e  dbg_state;
  logic [3:0]  dbg_starve;

  dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_mask(c_mask), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_rdata(c_rdata), .core_stall(core_stall),
    .x_valid(x_valid), .x_we(x_we), .x_mask(x_mask), .x_addr(x_addr),
    .x_wdata(x_wdata), .x_lock(x_lock), .x_ready(x_ready),
    .x_rvalid(x_rvalid), .x_rdata(x_rdata),
    .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve(dbg_starve)
  );

  // dmem environment: combinational read, masked write on the clock edge
  logic [31:0] dmem [16] = '{default: 32'h0};
  assign mem_rdata = dmem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) if (mem_mask[b]) dmem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;
  bit          model_ok = 0;
  bit          burst_owned;   // X holds the port for a burst
  int          x_waited;      // consecutive cycles the current X beat was refused
  bit          e_xg, e_cg;    // expected grants this cycle
  bit          x_acc, c_acc;  // beats accepted on the last edge
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e;
    if (!model_ok) return;
    // X wins when C is absent, when X owns a burst, or after LIMIT refusals.
    e_xg = !rst && x_valid && (burst_owned || !c_req || x_waited >= LIMIT);
    e_cg = !rst && c_req && !burst_owned && !e_xg;
    chk("x_ready", 32'(x_ready), 32'(e_xg));
    chk("core_stall", 32'(core_stall), 32'(c_req && !e_cg));
    chk("mem_we", 32'(mem_we), e_xg ? 32'(x_we) : e_cg ? 32'(c_we) : 32'h0);
    chk("mem_addr", mem_addr, e_xg ? x_addr : e_cg ? c_addr : 32'h0);
    chk("mem_wdata", mem_wdata, e_xg ? x_wdata : e_cg ? c_wdata : 32'h0);
    chk("mem_mask", 32'(mem_mask), e_xg ? 32'(x_mask) : e_cg ? 32'(c_mask) : 32'h0);
    chk("state", 32'(dbg_state == S_XLOCK), 32'(burst_owned));
    chk("starve", 32'(dbg_starve), 32'(x_waited));
    if (e_cg && !c_we) chk("c_rdata", c_rdata, ref_mem[c_addr[5:2]]);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("x_rvalid", 32'(x_rvalid), 32'h1);
      chk("x_rdata", x_rdata, e);
      last_rdata = e;
    end else begin
      chk("x_rvalid", 32'(x_rvalid), 32'h0);
      chk("x_rdata_hold", x_rdata, last_rdata);
    end
  endtask

  task automatic model_update();
    x_acc = 0;
    c_acc = 0;
    if (rst) begin
      burst_owned = 0;
      x_waited    = 0;
      last_rdata  = 32'h0;
      exp_q.delete();
      model_ok    = 1;
      return;
    end
    if (!model_ok) return;
    x_acc = e_xg;
    c_acc = e_cg;
    if (e_xg && !x_we) exp_q.push_back(ref_mem[x_addr[5:2]]);
    if (e_xg && x_we) ref_mem[x_addr[5:2]] = merge(ref_mem[x_addr[5:2]], x_wdata, x_mask);
    else if (e_cg && c_we) ref_mem[c_addr[5:2]] = merge(ref_mem[c_addr[5:2]], c_wdata, c_mask);
    if (burst_owned) burst_owned = x_valid && x_lock;
    else burst_owned = e_xg && x_lock;
    x_waited = (!x_valid || e_xg) ? 0 : (x_waited < LIMIT ? x_waited + 1 : LIMIT);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_c(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] d);
    c_req = req; c_we = we; c_addr = addr; c_wdata = d; c_mask = 4'hF;
  endtask

  task automatic drive_x(input bit v, input bit we, input logic [31:0] addr, input logic [31:0] d, input bit lock);
    x_valid = v; x_we = we; x_addr = addr; x_wdata = d; x_lock = lock; x_mask = 4'hF;
  endtask

  int waited;

  initial begin
    // 1. reset with both requesters active
    rst = 1;
    drive_c(1, 1, 32'h4, 32'h1111_1111);
    drive_x(1, 1, 32'h8, 32'h2222_2222, 0);
    cycle();
    cycle();
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    rst = 0;
    drive_c(0, 0, 0, 0);
    drive_x(0, 0, 0, 0, 0);
    cycle();

    // 2. core store then load of 0x10
    drive_c(1, 1, 32'h10, 32'hDEAD_BEEF);
    cycle();
    drive_c(1, 0, 32'h10, 32'h0);
    cycle();

    // 3. starvation relief: X read of 0x10 under continuous core traffic
    drive_x(1, 0, 32'h10, 32'h0, 0);
    waited = 0;
    for (int i = 0; i < 20 && !x_acc; i++) begin
      cycle();
      waited++;
    end
    chk("starve_grant_cycle", 32'(waited), 32'(LIMIT + 1));
    drive_x(0, 0, 0, 0, 0);
    cycle();

    // 4. locked write burst, core raises its request mid-burst
    drive_c(0, 0, 0, 0);
    for (int b = 0; b < 4; b++) begin
      drive_x(1, 1, 32'h20 + 32'(4 * b), 32'hA000_0000 + 32'(b), b != 3);
      if (b == 2) drive_c(1, 0, 32'h24, 32'h0);
      cycle();
    end
    drive_x(0, 0, 0, 0, 0);
    cycle();

    // 5. simultaneous request with no accumulated wait: C wins
    drive_c(1, 0, 32'h20, 32'h0);
    drive_x(1, 0, 32'h2C, 32'h0, 0);
    cycle();
    chk("starve_after_one", 32'(dbg_starve), 32'h1);
    drive_c(0, 0, 0, 0);
    cycle();
    drive_x(0, 0, 0, 0, 0);
    cycle();

    // 6. reset during a burst right after an accepted read
    drive_x(1, 0, 32'h28, 32'h0, 1);
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    drive_x(0, 0, 0, 0, 0);
    drive_c(1, 0, 32'h28, 32'h0);
    cycle();
    chk("post_rst_rvalid", 32'(x_rvalid), 32'h0);

    // randomized traffic, honouring hold-while-stalled on both ports
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!(c_req && !c_acc)) begin
        drive_c($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 15)) << 2, $urandom);
        c_mask = 4'($urandom_range(1, 15));
      end
      if (!(x_valid && !x_acc)) begin
        drive_x($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 15)) << 2, $urandom, $urandom_range(0, 2) == 0);
        x_mask = 4'($urandom_range(1, 15));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
